// File: rtl/mmap_ws_gen2.sv
// Z80 memory mapper: 2^PAGE_BITS IO-programmable windows onto a 512 KB space, chip-enable decode, slow-window wait states.
// Latency: SYNC input stages, then one registered stage on M_A/CE/D_OUT; map/control writes land two cycles after the strobe edge.
// Backpressure: holds WAIT_n low for WS_SLOW cycles on slow-window memory accesses when WS_EN is set; IO path never stalls.
module mmap_ws_gen2 #(
  parameter int         PAGE_BITS = 2,
  parameter logic [7:0] IO_BASE   = 8'h10,
  parameter int         WS_SLOW   = 3,
  parameter int         SYNC      = 2
) (
  input  logic        CLK_24MHz,
  input  logic        RES,
  input  logic [15:0] A,
  input  logic [7:0]  D_IN,
  input  logic        IORQ,
  input  logic        MREQ,
  input  logic        RD,
  input  logic        WR,
  input  logic        M1,
  output logic [7:0]  D_OUT,
  output logic        D_OE,
  output logic [4:0]  M_A,
  output logic        ROM_CE,
  output logic        RAM2_CE,
  output logic        RAM0_CE,
  output logic        RAM1_CE,
  output logic        WAIT_n
);

  localparam int         NWIN    = 1 << PAGE_BITS;
  localparam logic [3:0] WS_LOAD = 4'(WS_SLOW - 1);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} ws_state_t;

  // Synchroniser chains; strobes packed as {iorq, mreq, rd, wr, m1}
  logic [15:0] a_sync  [SYNC];
  logic [7:0]  d_sync  [SYNC];
  logic [4:0]  st_sync [SYNC];

  logic [15:0] s_a;
  logic [7:0]  s_d;
  logic        s_iorq, s_mreq, s_rd, s_wr, s_m1;

  // Edge-detect history of the synchronised strobes
  logic        prev_iow;
  logic        prev_mreq;

  // Register file
  logic [7:0]  map_q [NWIN];
  logic        lock;
  logic        ws_en;

  // Write pipeline: address decoded on the strobe edge, data taken a cycle later
  logic                 wr_pend;
  logic                 wr_map;
  logic                 wr_ctl;
  logic [PAGE_BITS-1:0] wr_idx;

  // Wait-state machine
  ws_state_t   state;
  logic [3:0]  cnt;

  // Decode helpers
  logic                 s_iow;
  logic                 io_wr_det;
  logic [8:0]           io_off;
  logic                 map_hit;
  logic                 ctl_hit;
  logic [PAGE_BITS-1:0] io_idx;
  logic [7:0]           ctrl_val;
  logic                 rd_act;
  logic [PAGE_BITS-1:0] win;
  logic [7:0]           sel;
  logic                 wp_block;
  logic                 mreq_fall;
  logic                 slow_start;

  assign s_a    = a_sync[SYNC-1];
  assign s_d    = d_sync[SYNC-1];
  assign s_iorq = st_sync[SYNC-1][4];
  assign s_mreq = st_sync[SYNC-1][3];
  assign s_rd   = st_sync[SYNC-1][2];
  assign s_wr   = st_sync[SYNC-1][1];
  assign s_m1   = st_sync[SYNC-1][0];

  // IO decode works on the low address byte, offset from the window base
  assign s_iow     = s_iorq | s_wr;
  assign io_wr_det = prev_iow & ~s_iow & s_m1;
  assign io_off    = {1'b0, s_a[7:0]} - {1'b0, IO_BASE};
  assign map_hit   = io_off < 9'(NWIN);
  assign ctl_hit   = io_off == 9'(NWIN);
  assign io_idx    = io_off[PAGE_BITS-1:0];
  assign ctrl_val  = {6'b0, ws_en, lock};
  assign rd_act    = ~s_iorq & ~s_rd & (map_hit | ctl_hit);

  // Memory side: top address bits pick the window entry
  assign win        = s_a[15 -: PAGE_BITS];
  assign sel        = map_q[win];
  assign wp_block   = sel[7] & ~s_mreq & ~s_wr;
  assign mreq_fall  = prev_mreq & ~s_mreq;
  assign slow_start = mreq_fall & s_m1 & ws_en & ~sel[6];

  // Shift bus inputs through the synchroniser stages; strobes idle high
  always_ff @(posedge CLK_24MHz) begin
    if (RES) begin
      for (int i = 0; i < SYNC; i++) begin
        a_sync[i]  <= '0;
        d_sync[i]  <= '0;
        st_sync[i] <= '1;
      end
      prev_iow  <= 1'b1;
      prev_mreq <= 1'b1;
    end else begin
      a_sync[0]  <= A;
      d_sync[0]  <= D_IN;
      st_sync[0] <= {IORQ, MREQ, RD, WR, M1};
      for (int i = 1; i < SYNC; i++) begin
        a_sync[i]  <= a_sync[i-1];
        d_sync[i]  <= d_sync[i-1];
        st_sync[i] <= st_sync[i-1];
      end
      prev_iow  <= s_iow;
      prev_mreq <= s_mreq;
    end
  end

  // Capture the IO write target on the strobe edge, load data the next cycle; LOCK freezes the map
  always_ff @(posedge CLK_24MHz) begin
    if (RES) begin
      for (int i = 0; i < NWIN; i++) map_q[i] <= 8'h00;
      lock    <= 1'b0;
      ws_en   <= 1'b0;
      wr_pend <= 1'b0;
      wr_map  <= 1'b0;
      wr_ctl  <= 1'b0;
      wr_idx  <= '0;
    end else begin
      wr_pend <= io_wr_det;
      wr_map  <= map_hit;
      wr_ctl  <= ctl_hit;
      wr_idx  <= io_idx;
      if (wr_pend) begin
        if (wr_map && !lock) map_q[wr_idx] <= s_d;
        if (wr_ctl) begin
          lock  <= lock | s_d[0];
          ws_en <= s_d[1];
        end
      end
    end
  end

  // Registered IO readback; bus driven only while an in-range read is active
  always_ff @(posedge CLK_24MHz) begin
    if (RES) begin
      D_OE  <= 1'b0;
      D_OUT <= 8'h00;
    end else begin
      D_OE <= rd_act;
      if (!rd_act)      D_OUT <= 8'h00;
      else if (map_hit) D_OUT <= map_q[io_idx];
      else              D_OUT <= ctrl_val;
    end
  end

  // Registered page address and one-hot-low chip enables; protected writes suppress every CE
  always_ff @(posedge CLK_24MHz) begin
    if (RES) begin
      M_A     <= 5'h00;
      ROM_CE  <= 1'b0;
      RAM2_CE <= 1'b1;
      RAM0_CE <= 1'b1;
      RAM1_CE <= 1'b1;
    end else begin
      M_A     <= sel[4:0];
      ROM_CE  <= 1'b1;
      RAM2_CE <= 1'b1;
      RAM0_CE <= 1'b1;
      RAM1_CE <= 1'b1;
      if (!wp_block) begin
        if (!sel[6]) begin
          if (sel[5]) RAM2_CE <= 1'b0;
          else        ROM_CE  <= 1'b0;
        end else begin
          if (sel[1]) RAM1_CE <= 1'b0;
          else        RAM0_CE <= 1'b0;
        end
      end
    end
  end

  // Wait-state FSM: WAIT_n low for WS_SLOW cycles per slow access, abort if MREQ rises early
  always_ff @(posedge CLK_24MHz) begin
    if (RES) begin
      state  <= IDLE;
      WAIT_n <= 1'b1;
      cnt    <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (slow_start) begin
            state  <= WAIT;
            WAIT_n <= 1'b0;
            cnt    <= WS_LOAD;
          end
        end
        WAIT: begin
          if (s_mreq) begin
            state  <= IDLE;
            WAIT_n <= 1'b1;
          end else if (cnt == 4'd0) begin
            state  <= HOLD;
            WAIT_n <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (s_mreq) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          WAIT_n <= 1'b1;
        end
      endcase
    end
  end

endmodule
